mux4_rr_arbiter: RTL

Round-robin arbiter that shares a single W-bit output channel between four valid/ready requesters. It sequences the 4:1 data mux select, so the downstream channel always sees data from exactly one granted lane. The output stage is registered. The block sits between four producer lanes and one shared consumer, and is the sequencing controller for the team's 4-to-1 mux datapath.

---
 rtl/mux4_rr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering four valid/ready lanes onto one registered W-bit output channel.
// Define ARB_BURST_LOCK_EN to hold a grant across beats until in_last or MAX_BURST beats.
module mux4_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     in_valid,
    input  logic [3:0]     in_last,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [1:0]     out_src,
    input  logic           out_ready,
    output logic [1:0]     sel,
    output logic           busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt, sel_nxt;
    logic [1:0] search_base, winner;
    logic       found;
    logic       lane_rdy, xfer, rls;
    logic       burst_end;

    if (MAX_BURST < 1) begin : g_cfg_check
        $error("MAX_BURST must be at least 1");
    end

    // First requesting lane at or after base, wrapping modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [2:0] pick;
        logic [1:0] lane;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            lane = base + 2'(k);
            if (req[lane]) pick = {1'b1, lane};
        end
        return pick;
    endfunction

`ifdef ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

    always_comb begin
        beat_cnt_nxt = beat_cnt + CNT_W'(1);
        burst_end    = in_last[sel] || (beat_cnt_nxt == CNT_W'(MAX_BURST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (rls) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt_nxt;
        end
    end
`else
    assign burst_end = 1'b1;
`endif

    always_comb begin
        lane_rdy      = (state == GRANT) && (!out_valid || out_ready);
        in_ready      = 4'b0000;
        in_ready[sel] = lane_rdy;
        xfer          = lane_rdy && in_valid[sel];
        rls           = xfer && burst_end;
        busy          = (state == GRANT);

        // On release the search starts just past the released lane, leaving it last in line.
        search_base      = (state == GRANT) ? (sel + 2'd1) : ptr;
        {found, winner}  = rr_pick(in_valid, search_base);

        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt   = winner;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rls) begin
                    ptr_nxt = sel + 2'd1;
                    if (found) begin
                        sel_nxt = winner;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
        end
    end

    // Output stage: loads on transfer, drains when the consumer takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[sel*W +: W];
            out_last  <= in_last[sel];
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
